// File: rtl/fetch_queue_unit.sv
// Fetch stage with PC ownership and a DEPTH-entry instruction queue toward decode.
// Optional static backward-taken branch prediction is enabled by FETCH_BTFN_EN.
module fetch_queue_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        stall,
  input  logic                        PCSrc,
  input  logic [ADDR_WIDTH-1:0]       PCTarget,
  output logic [ADDR_WIDTH-1:0]       imem_addr,
  input  logic [DATA_WIDTH-1:0]       imem_rdata,
  input  logic                        imem_ready,
  output logic                        ValidD,
  output logic [DATA_WIDTH-1:0]       InstrD,
  output logic [ADDR_WIDTH-1:0]       PCD,
  output logic [ADDR_WIDTH-1:0]       PCPlus4D,
  output logic                        PredTakenD,
  output logic [$clog2(DEPTH):0]      QCount
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] r_pc;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [CNT_W-1:0]      r_count;

  logic [DATA_WIDTH-1:0] r_instr_q [DEPTH];
  logic [ADDR_WIDTH-1:0] r_pc_q    [DEPTH];
  logic [ADDR_WIDTH-1:0] r_pc4_q   [DEPTH];

  logic                  w_valid;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic [ADDR_WIDTH-1:0] w_pc_plus4;
  logic [ADDR_WIDTH-1:0] w_pc_next;

  assign w_valid    = (r_count != '0);
  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_pop      = w_valid && !stall && !PCSrc;
  assign w_push     = imem_ready && !PCSrc && (!w_full || w_pop);
  assign w_pc_plus4 = r_pc + ADDR_WIDTH'(4);

`ifdef FETCH_BTFN_EN
  // Backward conditional branches (sign bit set) are predicted taken.
  logic        w_pred;
  logic [12:0] w_bimm;
  logic        r_pred_q [DEPTH];

  assign w_bimm    = {imem_rdata[31], imem_rdata[7], imem_rdata[30:25], imem_rdata[11:8], 1'b0};
  assign w_pred    = (imem_rdata[6:0] == 7'b1100011) && imem_rdata[31];
  assign w_pc_next = w_pred ? (r_pc + {{(ADDR_WIDTH-13){w_bimm[12]}}, w_bimm}) : w_pc_plus4;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pred_q[r_wr_ptr] <= w_pred;
    end
  end

  assign PredTakenD = w_valid ? r_pred_q[r_rd_ptr] : 1'b0;
`else
  assign w_pc_next  = w_pc_plus4;
  assign PredTakenD = 1'b0;
`endif

  // Queue payload storage; contents are meaningless outside the occupied window.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr_q[r_wr_ptr] <= imem_rdata;
      r_pc_q[r_wr_ptr]    <= r_pc;
      r_pc4_q[r_wr_ptr]   <= w_pc_plus4;
    end
  end

  // PC, pointers and occupancy; a redirect empties the queue and reloads the PC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc     <= RESET_PC;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (PCSrc) begin
      r_pc     <= PCTarget & ~ADDR_WIDTH'(3);
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        r_pc     <= w_pc_next;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  assign imem_addr = r_pc;
  assign ValidD    = w_valid;
  assign QCount    = r_count;
  assign InstrD    = w_valid ? r_instr_q[r_rd_ptr] : '0;
  assign PCD       = w_valid ? r_pc_q[r_rd_ptr]    : '0;
  assign PCPlus4D  = w_valid ? r_pc4_q[r_rd_ptr]   : '0;

endmodule
